pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage RV32 pipeline.
- Drives per-stage hold (stall) and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC-source select.
- Resolves load-use, taken branch, multi-cycle MDU, data-memory wait and trap redirect.
- Adds a post-trap fetch-drain sequence and a saturating stall-cycle counter.

Parameters:
- DRAIN_CYCLES, 2: cycles IF/ID is flushed after a trap redirect; legal range 1..15.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_mdu_start  in  1  EX holds a mul/div; MDU starts this cycle
- mdu_done  in  1  MDU result valid this cycle
- mem_req, mem_ready  in  1 each  MEM-stage data request; slave ready
- trap_req  in  1  exception or interrupt commit request, level
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each  bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
- pc_sel  out  2  0=PC+4, 1=branch target, 2=trap vector, 3 unused
- mdu_kill  out  1  abort the in-flight MDU operation
- busy_state  out  2  0=RUN, 1=MDU_WAIT, 2=DRAIN
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Reset (async): state=RUN, drain count=0, stall_cycles=0. While reset is high:
  - all flush_*=1
  - all stall_*=0
  - pc_sel=0, mdu_kill=0
- All stall/flush/pc_sel/mdu_kill outputs are combinational from the current state and inputs. State and counters update on posedge clk.
- Load-use hazard: lu = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Memory wait: mw = mem_req & ~mem_ready.
- Priority, highest first, evaluated every cycle:
  1. trap_req, any state:
     - flush_id=flush_ex=flush_mem=1, pc_sel=2, all stalls 0.
     - mdu_kill=1 if state=MDU_WAIT or ex_mdu_start.
     - Next state DRAIN, drain count=DRAIN_CYCLES-1.
  2. mw: stall_if=stall_id=stall_ex=stall_mem=1, flush_wb=1. State unchanged; an MDU in progress keeps running.
  3. state=MDU_WAIT:
     - If ~mdu_done: stall_if=stall_id=stall_ex=1, flush_mem=1.
     - If mdu_done: no stall, next state RUN. A mdu_done arriving during mw is still honoured for the transition.
  4. ex_mdu_start in RUN: stall_if=stall_id=stall_ex=1, flush_mem=1, next state MDU_WAIT. A same-cycle mdu_done (single-cycle op) means no stall and stay in RUN.
  5. ex_branch_taken: flush_id=flush_ex=1, pc_sel=1. This overrides lu: the stall is suppressed because the ID instruction is squashed.
  6. lu: stall_if=stall_id=1, flush_ex=1 (one bubble). The cycle after, EX holds the bubble, so lu drops naturally.
- DRAIN state:
  - flush_id=1 each cycle; decrement count.
  - Exit to RUN in the cycle after count==0, so DRAIN_CYCLES cycles total.
  - mw still stalls in DRAIN and the count pauses. Branch and lu are ignored in DRAIN.
  - A new trap_req restarts the count.
- stall_cycles increments when stall_if=1 and saturates at all-ones.
- Reset mid-MDU or mid-DRAIN returns to RUN immediately. No mdu_kill is issued; the MDU has its own reset.

Test Plan:
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5), ID add with rs1=5, uses_rs1=1 -> one cycle stall_if=stall_id=flush_ex=1, next cycle all 0; stall_cycles=1.
- Same as above with ex_rd=0, or uses_rs1=0 -> no stall. Load-use plus ex_branch_taken together -> flush_id=flush_ex=1, pc_sel=1, stall_if=0.
- Multi-cycle MDU: ex_mdu_start=1, mdu_done after 33 cycles -> stall_if/id/ex and flush_mem=1 for 33 cycles, busy_state=1, release on the done cycle; stall_cycles=33.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles during MDU_WAIT -> all four stalls plus flush_wb for 3 cycles, busy_state stays 1.
- Trap: trap_req during MDU_WAIT -> mdu_kill=1, pc_sel=2, flush_id/ex/mem=1. Then flush_id=1 for 2 cycles (DRAIN_CYCLES=2) with busy_state=2, then RUN.
- Reset and saturation: CNT_W=4 with 20 stall cycles -> stall_cycles=15. Assert reset mid-DRAIN -> busy_state=0, all flush=1, counter=0 asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stalls, flushes,
// PC source select, MDU wait, post-trap fetch drain and a saturating stall counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; load-use, branch and MDU start resolved here
// MDU_WAIT | multi-cycle mul/div in EX; front of pipe held until mdu_done
// DRAIN    | after a trap redirect, IF/ID flushed for DRAIN_CYCLES cycles
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             trap_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic [1:0]       pc_sel,
    output logic             mdu_kill,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] drain_cnt, drain_cnt_nxt;
    logic       lu, mw;

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mw = mem_req && !mem_ready;

    assign busy_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        if (trap_req) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
        end else begin
            case (state)
                RUN: begin
                    if (!mw && ex_mdu_start && !mdu_done)
                        state_nxt = MDU_WAIT;
                end
                // mdu_done is honoured even while a memory wait holds the pipe
                MDU_WAIT: begin
                    if (mdu_done)
                        state_nxt = RUN;
                end
                DRAIN: begin
                    if (!mw) begin
                        if (drain_cnt == 4'd0)
                            state_nxt = RUN;
                        else
                            drain_cnt_nxt = drain_cnt - 4'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;
        pc_sel    = 2'd0;
        mdu_kill  = 1'b0;
        if (reset) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (trap_req) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            pc_sel    = 2'd2;
            mdu_kill  = (state == MDU_WAIT) || ex_mdu_start;
        end else if (mw) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (state == DRAIN) begin
            flush_id = 1'b1;
        end else if (state == MDU_WAIT) begin
            if (!mdu_done) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                flush_mem = 1'b1;
            end
        end else if (ex_mdu_start && !mdu_done) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
        end else if (ex_branch_taken) begin
            // the ID instruction is squashed, so a pending load-use stall is moot
            flush_id = 1'b1;
            flush_ex = 1'b1;
            pc_sel   = 2'd1;
        end else if (lu) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall_if && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with a 4-bit counter
// exercises stall-count saturation on the same stimulus.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        ex_mdu_start, mdu_done, mem_req, mem_ready, trap_req;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_mem, flush_wb, mdu_kill;
    logic [1:0]  pc_sel, busy_state;
    logic [15:0] stall_cycles;
    logic        s4_if, s4_id, s4_ex, s4_mem, f4_id, f4_ex, f4_mem, f4_wb, k4;
    logic [1:0]  p4, b4;
    logic [3:0]  stall_cycles4;
    logic [10:0] ctl;

    int n_checks = 0;
    int n_errors = 0;

    // {stall if,id,ex,mem | flush id,ex,mem,wb | pc_sel | mdu_kill}
    localparam logic [10:0] C_IDLE  = 11'b0000_0000_00_0;
    localparam logic [10:0] C_RST   = 11'b0000_1111_00_0;
    localparam logic [10:0] C_LU    = 11'b1100_0100_00_0;
    localparam logic [10:0] C_BR    = 11'b0000_1100_01_0;
    localparam logic [10:0] C_MDU   = 11'b1110_0010_00_0;
    localparam logic [10:0] C_MW    = 11'b1111_0001_00_0;
    localparam logic [10:0] C_TRAPK = 11'b0000_1110_10_1;
    localparam logic [10:0] C_TRAP  = 11'b0000_1110_10_0;
    localparam logic [10:0] C_DRAIN = 11'b0000_1000_00_0;

    always #5 clk = ~clk;

    assign ctl = {stall_if, stall_id, stall_ex, stall_mem,
                  flush_id, flush_ex, flush_mem, flush_wb, pc_sel, mdu_kill};

    pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .mem_req(mem_req), .mem_ready(mem_ready), .trap_req(trap_req),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
        .pc_sel(pc_sel), .mdu_kill(mdu_kill), .busy_state(busy_state),
        .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .mem_req(mem_req), .mem_ready(mem_ready), .trap_req(trap_req),
        .stall_if(s4_if), .stall_id(s4_id), .stall_ex(s4_ex), .stall_mem(s4_mem),
        .flush_id(f4_id), .flush_ex(f4_ex), .flush_mem(f4_mem), .flush_wb(f4_wb),
        .pc_sel(p4), .mdu_kill(k4), .busy_state(b4),
        .stall_cycles(stall_cycles4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [10:0] exp);
        check(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic chk_busy(input string tag, input logic [1:0] exp);
        check(tag, 32'(busy_state), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag, input int exp16, input int exp4);
        check({tag, "_cnt16"}, 32'(stall_cycles), exp16);
        check({tag, "_cnt4"}, 32'(stall_cycles4), exp4);
    endtask

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; trap_req = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #3;
        chk_ctl("reset_ctl", C_RST);
        chk_busy("reset_busy", 2'd0);
        chk_cnt("reset", 0, 0);
        #9 reset = 1'b0;

        // load-use: one bubble, then clear
        cyc();
        set_lu();
        #1 chk_ctl("lu", C_LU);
        cyc();
        clr();
        #1 chk_ctl("lu_after", C_IDLE);
        chk_cnt("lu", 1, 1);

        // load-use qualifiers and branch override, all within one cycle
        ex_mem_read = 1'b1; id_uses_rs1 = 1'b1;
        #1 chk_ctl("lu_rd0", C_IDLE);
        ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0;
        #1 chk_ctl("lu_nouse", C_IDLE);
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1 chk_ctl("lu_rs2", C_LU);
        ex_branch_taken = 1'b1;
        #1 chk_ctl("lu_branch", C_BR);
        clr();

        // 33-cycle MDU
        cyc();
        ex_mdu_start = 1'b1;
        #1 chk_ctl("mdu_start", C_MDU);
        cyc();
        clr();
        for (int i = 0; i < 32; i++) begin
            #1 chk_ctl("mdu_wait", C_MDU);
            chk_busy("mdu_busy", 2'd1);
            cyc();
        end
        mdu_done = 1'b1;
        #1 chk_ctl("mdu_done", C_IDLE);
        chk_busy("mdu_done_busy", 2'd1);
        cyc();
        clr();
        #1 chk_busy("mdu_release", 2'd0);
        chk_cnt("mdu", 34, 15);

        // single-cycle MDU: no stall, stay in RUN
        ex_mdu_start = 1'b1; mdu_done = 1'b1;
        #1 chk_ctl("mdu_1cyc", C_IDLE);
        cyc();
        clr();
        #1 chk_busy("mdu_1cyc_busy", 2'd0);

        // memory wait inside MDU_WAIT, then trap kills the MDU
        ex_mdu_start = 1'b1;
        cyc();
        clr();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctl("mw_in_mdu", C_MW);
            chk_busy("mw_busy", 2'd1);
            cyc();
        end
        clr();
        #1 chk_ctl("mdu_after_mw", C_MDU);
        chk_busy("mdu_after_mw_busy", 2'd1);
        cyc();
        trap_req = 1'b1;
        #1 chk_ctl("trap_mdu", C_TRAPK);
        cyc();
        clr();
        #1 chk_ctl("drain1", C_DRAIN);
        chk_busy("drain1_busy", 2'd2);
        cyc();
        #1 chk_ctl("drain2", C_DRAIN);
        chk_busy("drain2_busy", 2'd2);
        cyc();
        #1 chk_ctl("drain_exit", C_IDLE);
        chk_busy("drain_exit_busy", 2'd0);
        chk_cnt("trap", 39, 15);

        // mdu_done during a memory wait still leaves MDU_WAIT
        ex_mdu_start = 1'b1;
        cyc();
        clr();
        mem_req = 1'b1; mdu_done = 1'b1;
        #1 chk_ctl("mw_done", C_MW);
        cyc();
        clr();
        #1 chk_busy("mw_done_busy", 2'd0);
        chk_cnt("mw_done", 41, 15);

        // trap with MDU starting in RUN; drain ignores branch/lu, pauses on mw
        trap_req = 1'b1; ex_mdu_start = 1'b1;
        #1 chk_ctl("trap_start", C_TRAPK);
        cyc();
        clr();
        set_lu(); ex_branch_taken = 1'b1;
        #1 chk_ctl("drain_ignore", C_DRAIN);
        clr();
        mem_req = 1'b1;
        #1 chk_ctl("drain_mw", C_MW);
        cyc();
        clr();
        #1 chk_busy("drain_pause", 2'd2);
        cyc();
        #1 chk_busy("drain_last", 2'd2);
        cyc();
        #1 chk_busy("drain_pause_exit", 2'd0);

        // reset mid-DRAIN takes effect immediately
        trap_req = 1'b1;
        #1 chk_ctl("trap_run", C_TRAP);
        cyc();
        clr();
        #1 chk_busy("drain_pre_rst", 2'd2);
        chk_cnt("pre_rst", 42, 15);
        reset = 1'b1;
        #1 chk_ctl("rst_mid_ctl", C_RST);
        chk_busy("rst_mid_busy", 2'd0);
        chk_cnt("rst_mid", 0, 0);
        #3 reset = 1'b0;
        cyc();
        chk_busy("post_rst_busy", 2'd0);

        // 20 stall cycles: 4-bit counter saturates at 15
        set_lu();
        for (int i = 0; i < 20; i++) cyc();
        clr();
        #1 chk_cnt("sat", 20, 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
